// File: rtl/ro_meter_pkg.sv
// Shared constants for the ring-oscillator frequency meter: register map,
// CTRL/STATUS bit positions and the measurement FSM states.
package ro_meter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_GATE   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_GO      = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_OSC_LSB = 4;
  localparam int CTRL_MUX_LSB = 12;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Brings the asynchronous oscillator output into the clock domain and emits a
// one-cycle pulse per rising edge seen after synchronization.
module ro_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: Wishbone register file plus a settle/measure
// FSM counting synchronized oscillator rising edges over a programmable gate.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int GATE_W      = 24,
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        ro_i,
  output logic [4:0]  ro_sel_o,
  output logic        ro_start_o,
  output logic [3:0]  mux_sel_o,
  output logic        busy_o
);

  state_t            state;
  logic [31:0]       timer;
  logic [GATE_W-1:0] gate;
  logic [CNT_W-1:0]  count;
  logic              done_f, ovf_f;
  logic [4:0]        osc_sel;
  logic [3:0]        mux_sel;
  logic              ro_rise;

  logic        acc, wr, busy;
  logic [1:0]  adr;
  logic [31:0] bmask, ctrl_img, ctrl_new, rdata;
  logic [GATE_W-1:0] gate_new;
  logic        go, abort, done_clr, ovf_clr;
  logic        unused;

  ro_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_ni),
    .din  (ro_i),
    .rise (ro_rise)
  );

  // A new access is accepted only while ack is low, forcing an idle cycle between accesses.
  assign acc   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr    = acc & wbs_we_i;
  assign adr   = wbs_adr_i[3:2];
  assign busy  = (state != IDLE);
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign go       = wr && adr == REG_CTRL   && wbs_sel_i[0] && wbs_dat_i[CTRL_GO];
  assign abort    = wr && adr == REG_CTRL   && wbs_sel_i[0] && wbs_dat_i[CTRL_ABORT];
  assign done_clr = wr && adr == REG_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_DONE];
  assign ovf_clr  = wr && adr == REG_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_OVF];

  always_comb begin
    ctrl_img = '0;
    ctrl_img[CTRL_OSC_LSB +: 5] = osc_sel;
    ctrl_img[CTRL_MUX_LSB +: 4] = mux_sel;
    ctrl_new = (ctrl_img & ~bmask) | (wbs_dat_i & bmask);
    gate_new = (gate & ~bmask[GATE_W-1:0]) | (wbs_dat_i[GATE_W-1:0] & bmask[GATE_W-1:0]);
  end

  always_comb begin
    rdata = '0;
    case (adr)
      REG_CTRL:   rdata = ctrl_img;
      REG_GATE:   rdata[GATE_W-1:0] = gate;
      REG_COUNT:  rdata[CNT_W-1:0]  = count;
      default: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done_f;
        rdata[STAT_OVF]  = ovf_f;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      osc_sel   <= '0;
      mux_sel   <= '0;
      gate      <= '0;
    end else begin
      wbs_ack_o <= acc;
      if (acc) wbs_dat_o <= rdata;
      // Configuration is frozen for the whole measurement.
      if (wr && !busy && adr == REG_CTRL) begin
        osc_sel <= ctrl_new[CTRL_OSC_LSB +: 5];
        mux_sel <= ctrl_new[CTRL_MUX_LSB +: 4];
      end
      if (wr && !busy && adr == REG_GATE) gate <= gate_new;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      timer      <= '0;
      count      <= '0;
      done_f     <= 1'b0;
      ovf_f      <= 1'b0;
      ro_start_o <= 1'b0;
    end else begin
      if (done_clr) done_f <= 1'b0;
      if (ovf_clr)  ovf_f  <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        ro_start_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (go) begin
            state      <= SETTLE;
            count      <= '0;
            ovf_f      <= 1'b0;
            timer      <= 32'(SETTLE_CYC - 1);
            ro_start_o <= 1'b1;
          end
          SETTLE: if (timer == '0) begin
            if (gate != '0) begin
              state <= MEASURE;
              timer <= 32'(gate) - 32'd1;
            end else begin
              state      <= DONE;
              ro_start_o <= 1'b0;
            end
          end else begin
            timer <= timer - 32'd1;
          end
          MEASURE: begin
            if (ro_rise) begin
              if (count == '1) ovf_f <= 1'b1;
              else             count <= count + CNT_W'(1);
            end
            if (timer == '0) begin
              state      <= DONE;
              ro_start_o <= 1'b0;
            end else begin
              timer <= timer - 32'd1;
            end
          end
          DONE: begin
            state  <= IDLE;
            done_f <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ro_sel_o  = osc_sel;
  assign mux_sel_o = mux_sel;
  assign busy_o    = busy;
  assign unused    = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], ctrl_new};

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: register table, directed corner sequences and
// randomized gate/oscillator-period runs checked against an edge-count model.
module tb_ro_freq_meter;
  import ro_meter_pkg::*;

  localparam int SETTLE = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc1 = 1'b0, stb1 = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ro = 1'b0;
  logic        ack0, ack1, start0, start1, busy0, busy1;
  logic [31:0] dat0, dat1;
  logic [4:0]  rosel0, rosel1;
  logic [3:0]  mux0, mux1;

  int checks = 0, failures = 0, cyc_n = 0, ack_cyc = 0, ro_half = 20;

  ro_freq_meter u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc0), .wbs_stb_i(stb0),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack0), .wbs_dat_o(dat0), .ro_i(ro), .ro_sel_o(rosel0),
    .ro_start_o(start0), .mux_sel_o(mux0), .busy_o(busy0)
  );

  ro_freq_meter #(.CNT_W(4)) u_dut4 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc1), .wbs_stb_i(stb1),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack1), .wbs_dat_o(dat1), .ro_i(ro), .ro_sel_o(rosel1),
    .ro_start_o(start1), .mux_sel_o(mux1), .busy_o(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Free-running oscillator, phase-offset from the clock.
  initial begin
    #3;
    forever #(ro_half) ro = ~ro;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wb(input int which, input logic w, input logic [1:0] a,
                    input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    we = w; adr = {28'd0, a, 2'b00}; wdat = d; sel = s;
    if (which == 1) begin cyc1 = 1'b1; stb1 = 1'b1; end
    else            begin cyc0 = 1'b1; stb0 = 1'b1; end
    do begin
      @(posedge clk); #1; n++;
    end while (((which == 1) ? ack1 : ack0) !== 1'b1 && n < 20);
    chk("wb_ack", (which == 1) ? ack1 : ack0, 1);
    rd = (which == 1) ? dat1 : dat0;
    ack_cyc = cyc_n;
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb(which, 1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic rd(input int which, input logic [1:0] a, output logic [31:0] d);
    wb(which, 1'b0, a, 32'd0, 4'hF, d);
  endtask

  task automatic go(input int which, input int gate_len, input logic [4:0] osc, input logic [3:0] mx);
    wr(which, REG_GATE, gate_len);
    wr(which, REG_CTRL, {16'd0, mx, 3'd0, osc, 4'd0} | 32'd1);
  endtask

  // Returns cycles from the GO ack until busy drops, and cycles with ro_start high.
  task automatic wait_idle(input int which, output int dur, output int hi);
    int n;
    n = 0; hi = 0;
    while (((which == 1) ? busy1 : busy0) && n < 3000) begin
      if ((which == 1) ? start1 : start0) hi++;
      @(posedge clk); #1; n++;
    end
    chk("busy_drop", (which == 1) ? busy1 : busy0, 0);
    dur = n;
  endtask

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic [4:0]  exp_osc;
    logic [3:0]  exp_mux;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] r;
    int dur, hi, n0, half, gl;
    real e;

    tbl[0] = '{REG_GATE,   32'h1234_5678, 4'hF, 32'h0034_5678, 5'h00, 4'h0};
    tbl[1] = '{REG_GATE,   32'hAABB_CCDD, 4'h2, 32'h0034_CC78, 5'h00, 4'h0};
    tbl[2] = '{REG_CTRL,   32'hFFFF_F1F0, 4'hF, 32'h0000_F1F0, 5'h1F, 4'hF};
    tbl[3] = '{REG_CTRL,   32'h0000_2150, 4'h1, 32'h0000_F150, 5'h15, 4'hF};
    tbl[4] = '{REG_CTRL,   32'h0000_0000, 4'hC, 32'h0000_F150, 5'h15, 4'hF};
    tbl[5] = '{REG_COUNT,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 5'h15, 4'hF};
    tbl[6] = '{REG_STATUS, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 5'h15, 4'hF};
    tbl[7] = '{REG_CTRL,   32'h0000_0000, 4'hF, 32'h0000_0000, 5'h00, 4'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", ack0, 0);
    chk("rst_dat", dat0, 0);
    chk("rst_rosel", rosel0, 0);
    chk("rst_start", start0, 0);
    chk("rst_mux", mux0, 0);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    rd(0, REG_COUNT, r);  chk("rst_count", r, 0);
    rd(0, REG_STATUS, r); chk("rst_status", r, 0);

    // Register file table
    for (int i = 0; i < 8; i++) begin
      logic [31:0] dummy;
      wb(0, 1'b1, tbl[i].a, tbl[i].d, tbl[i].s, dummy);
      rd(0, tbl[i].a, r);
      chk($sformatf("tbl%0d_rd", i), r, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_osc", i), rosel0, tbl[i].exp_osc);
      chk($sformatf("tbl%0d_mux", i), mux0, tbl[i].exp_mux);
    end

    // Nominal: period 4 clocks, gate 100
    ro_half = 20;
    go(0, 100, 5'b00001, 4'd3);
    chk("a_rosel", rosel0, 1);
    chk("a_mux", mux0, 3);
    chk("a_busy", busy0, 1);
    wait_idle(0, dur, hi);
    chk("a_dur", dur, SETTLE + 100 + 1);
    chk("a_start_cycles", hi, SETTLE + 100);
    rd(0, REG_COUNT, r);  chk_rng("a_count", int'(r), 24, 26);
    rd(0, REG_STATUS, r); chk("a_status", r, 32'h2);

    // Zero gate skips the window
    go(0, 0, 5'b00001, 4'd3);
    wait_idle(0, dur, hi);
    chk("b_dur", dur, SETTLE + 1);
    chk("b_start_cycles", hi, SETTLE);
    rd(0, REG_COUNT, r);  chk("b_count", r, 0);

    // 4-bit counter saturation with period-2 oscillator
    ro_half = 10;
    go(1, 64, 5'b00010, 4'd5);
    chk("c_rosel", rosel1, 2);
    chk("c_mux", mux1, 5);
    wait_idle(1, dur, hi);
    chk("c_dur", dur, SETTLE + 64 + 1);
    rd(1, REG_COUNT, r);  chk("c_count", r, 15);
    rd(1, REG_STATUS, r); chk("c_status", r, 32'h6);
    wr(1, REG_STATUS, 32'h6);
    rd(1, REG_STATUS, r); chk("c_status_clr", r, 0);

    // Abort mid-window (GO and ABORT together), prior COUNT 25
    ro_half = 20;
    go(0, 100, 5'b00001, 4'd3);
    wait_idle(0, dur, hi);
    wr(0, REG_STATUS, 32'h6);
    go(0, 100, 5'b00001, 4'd3);
    repeat (54) @(posedge clk);
    #1;
    wr(0, REG_CTRL, 32'h0000_3013);
    chk("d_busy", busy0, 0);
    chk("d_start", start0, 0);
    rd(0, REG_STATUS, r); chk("d_status", r, 0);
    rd(0, REG_COUNT, r);  chk_rng("d_count", int'(r), 8, 12);

    // GO / config writes while busy are ignored
    go(0, 100, 5'b00001, 4'd3);
    n0 = ack_cyc;
    repeat (20) @(posedge clk);
    #1;
    wr(0, REG_CTRL, 32'h0000_5041);
    wr(0, REG_GATE, 32'd5);
    chk("e_rosel", rosel0, 1);
    chk("e_mux", mux0, 3);
    chk("e_busy", busy0, 1);
    wait_idle(0, dur, hi);
    chk("e_dur", cyc_n - n0, SETTLE + 100 + 1);
    rd(0, REG_GATE, r); chk("e_gate", r, 100);

    // Asynchronous reset mid-measurement
    go(0, 100, 5'b00001, 4'd3);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("f_start", start0, 0);
    chk("f_busy", busy0, 0);
    chk("f_rosel", rosel0, 0);
    chk("f_mux", mux0, 0);
    chk("f_ack", ack0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Randomized gate/period runs against the edge-count model
    for (int i = 0; i < 6; i++) begin
      half = $urandom_range(11, 40);
      gl   = $urandom_range(1, 150);
      ro_half = half;
      go(0, gl, 5'b00100, 4'd7);
      wait_idle(0, dur, hi);
      chk($sformatf("r%0d_dur", i), dur, SETTLE + gl + 1);
      e = (gl * 10.0) / (2.0 * half);
      rd(0, REG_COUNT, r);
      chk_rng($sformatf("r%0d_count", i), int'(r), int'($ceil(e - 1.0)), int'($floor(e + 1.0)));
      rd(0, REG_STATUS, r);
      chk($sformatf("r%0d_status", i), r, 32'h2);
      wr(0, REG_STATUS, 32'h2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
